alu_sequencer: RTL



---
 rtl/alu_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fixed-point arithmetic engine.
//
// Operands and results are signed two's-complement integers scaled by
// FRAC_SCALE (with FRAC_SCALE=100, 1.25 is held as 125). Add and subtract
// take one cycle. Multiply runs a shift-add multiplier followed by a
// restoring division of the double-width product by FRAC_SCALE. Divide
// pre-scales |a| by FRAC_SCALE and runs a restoring divider by |b|. Both
// work on magnitudes, so scaling truncates toward zero before the sign is
// applied. Overflow wraps mod 2^WIDTH.
//
// Handshake: a request is taken on a rising edge where start=1 and the
// engine is idle (busy=0); op/operand_a/operand_b are sampled only on that
// edge. start while busy=1 is dropped, never queued. busy falls on the same
// edge that raises done, and done is a one-cycle pulse; during the done
// cycle the engine is idle again, so a held start is taken on the next edge.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   start        request strobe
//   op           0 add, 1 subtract, 2 multiply, 3 divide
//   operand_a    signed scaled first operand
//   operand_b    signed scaled second operand
//   busy         operation in flight
//   done         one-cycle pulse, result valid
//   result       signed scaled result, held until the next done
//   div_by_zero  set with done for a divide by zero, cleared at acceptance
//   state_dbg    current FSM state, for observation only
module alu_sequencer #(
    parameter int WIDTH      = 64,
    parameter int FRAC_SCALE = 100
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE, ADDSUB, MUL_ITER, SCALE_ITER, DIV_ITER, FINISH
    } state_t;

    localparam int              CW         = $clog2(2 * WIDTH);
    localparam logic [6:0]      SCALE_BITS = 7'(FRAC_SCALE);
    localparam logic [WIDTH-1:0] SCALE_W   = WIDTH'(FRAC_SCALE);

    state_t               state;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 sub_q;
    logic                 sign_q;
    logic                 dz_q;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    // acc holds the product during MUL_ITER, then serves as the dividend /
    // quotient shift register for both SCALE_ITER and DIV_ITER.
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     den;
    logic [CW-1:0]        cnt;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic                 sign_in;
    logic [2*WIDTH-1:0]   num_scaled;
    logic [WIDTH:0]       trial;
    logic                 ge;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     rem_next;
    logic [2*WIDTH-1:0]   mul_sum;
    logic [WIDTH-1:0]     signed_mag;

    // The most negative operand negates to itself, which read as unsigned
    // is exactly its magnitude 2^(WIDTH-1).
    assign abs_a   = operand_a[WIDTH-1] ? WIDTH'(0) - operand_a : operand_a;
    assign abs_b   = operand_b[WIDTH-1] ? WIDTH'(0) - operand_b : operand_b;
    assign sign_in = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];

    // |a| * FRAC_SCALE by shift/add over the constant's set bits.
    always_comb begin
        num_scaled = '0;
        for (int i = 0; i < 7; i++) begin
            if (SCALE_BITS[i]) begin
                num_scaled = num_scaled + ({{WIDTH{1'b0}}, abs_a} << i);
            end
        end
    end

    // Restoring division step. The remainder is always below den, so the
    // shifted-in trial fits WIDTH+1 bits and the difference fits WIDTH bits.
    assign trial    = {rem, acc[2*WIDTH-1]};
    assign ge       = trial >= {1'b0, den};
    assign diff     = trial[WIDTH-1:0] - den;
    assign rem_next = ge ? diff : trial[WIDTH-1:0];

    assign mul_sum    = acc + (mplier[0] ? mcand : '0);
    assign signed_mag = sign_q ? WIDTH'(0) - acc[WIDTH-1:0] : acc[WIDTH-1:0];

    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            sign_q      <= 1'b0;
            dz_q        <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            rem         <= '0;
            den         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        dz_q        <= 1'b0;
                        a_q         <= operand_a;
                        b_q         <= operand_b;
                        sub_q       <= op[0];
                        sign_q      <= sign_in;
                        rem         <= '0;
                        case (op)
                            2'd0, 2'd1: state <= ADDSUB;
                            2'd2: begin
                                acc    <= '0;
                                mcand  <= {{WIDTH{1'b0}}, abs_a};
                                mplier <= abs_b;
                                den    <= SCALE_W;
                                cnt    <= CW'(WIDTH - 1);
                                state  <= MUL_ITER;
                            end
                            default: begin
                                if (operand_b == '0) begin
                                    acc   <= '0;
                                    dz_q  <= 1'b1;
                                    state <= FINISH;
                                end else begin
                                    acc   <= num_scaled;
                                    den   <= abs_b;
                                    cnt   <= CW'(2 * WIDTH - 1);
                                    state <= DIV_ITER;
                                end
                            end
                        endcase
                    end
                end
                ADDSUB: begin
                    result <= sub_q ? a_q - b_q : a_q + b_q;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                MUL_ITER: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == '0) begin
                        cnt   <= CW'(2 * WIDTH - 1);
                        state <= SCALE_ITER;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SCALE_ITER, DIV_ITER: begin
                    rem <= rem_next;
                    acc <= {acc[2*WIDTH-2:0], ge};
                    if (cnt == '0) begin
                        state <= FINISH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FINISH: begin
                    result      <= signed_mag;
                    div_by_zero <= dz_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
